// File: rtl/sd_pkg.sv
// Shared types, frame lengths and the CRC7 step for the SD host command engine.
package sd_pkg;

  typedef enum logic [1:0] {
    RESP_NONE      = 2'd0,
    RESP_R48       = 2'd1,
    RESP_R136      = 2'd2,
    RESP_R48_NOCRC = 2'd3
  } resp_type_t;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    SEND,
    TURN,
    WAIT_START,
    RECV,
    GAP
  } host_state_t;

  localparam logic [7:0] CMD_LEN     = 8'd48;
  localparam logic [7:0] CMD_CRC_POS = 8'd40;
  localparam logic [7:0] R48_LEN     = 8'd48;
  localparam logic [7:0] R136_LEN    = 8'd136;
  localparam logic [7:0] PRE_LEN     = 8'd2;

  // x^7 + x^3 + 1, MSB-first serial update
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
    logic fb;
    fb = crc[6] ^ b;
    return {crc[5:3], crc[2] ^ fb, crc[1:0], fb};
  endfunction

endpackage

// File: rtl/sd_host_cmd_if.sv
// Sequencer-side handshake and result bus of the SD host command engine.
interface sd_host_cmd_if;
  logic         start;
  logic [5:0]   cmd_idx;
  logic [31:0]  cmd_arg;
  logic [1:0]   resp_type;
  logic         busy;
  logic         done;
  logic [5:0]   resp_idx;
  logic [119:0] resp_arg;
  logic         crc_err;
  logic         idx_err;
  logic         timeout;

  modport master (
    output start, cmd_idx, cmd_arg, resp_type,
    input  busy, done, resp_idx, resp_arg, crc_err, idx_err, timeout
  );

  modport slave (
    input  start, cmd_idx, cmd_arg, resp_type,
    output busy, done, resp_idx, resp_arg, crc_err, idx_err, timeout
  );
endinterface

// File: rtl/sd_crc7.sv
// Serial CRC7 accumulator; clr restarts from zero, en folds in one bit.
module sd_crc7
  import sd_pkg::*;
(
  input  logic       sdclk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  always_ff @(posedge sdclk) begin
    if (!rst_n || clr) crc <= '0;
    else if (en)       crc <= crc7_step(crc, din);
  end

endmodule

// File: rtl/sd_host_cmd.sv
// SD host CMD-line engine: sends a 48-bit command, collects R48/R136 responses.
// Define SDHOST_R2_CRC_CHECK_EN to also check the CRC7 of R136 responses.
//
// state      | meaning
// IDLE       | line released, waiting for start
// PRE        | drive two idle ones before the start bit
// SEND       | shift out the 48-bit command frame
// TURN       | one released cycle before listening
// WAIT_START | look for the response start bit, bounded by RESP_TIMEOUT
// RECV       | shift in the rest of the response
// GAP        | NCC released cycles before the next command
module sd_host_cmd
  import sd_pkg::*;
#(
  parameter int unsigned RESP_TIMEOUT = 64,
  parameter int unsigned NCC          = 8
) (
  input  logic         sdclk,
  input  logic         rst_n,
  sd_host_cmd_if.slave bus,
  output logic         sdcmdoe,
  output logic         sdcmdout,
  input  logic         sdcmdin
);

  localparam int unsigned      TW       = $clog2(RESP_TIMEOUT + 1);
  localparam logic [TW-1:0]    TO_LIMIT = TW'(RESP_TIMEOUT);
  localparam logic [7:0]       GAP_LAST = 8'(NCC - 1);

  host_state_t   state;
  resp_type_t    rtype_q;
  logic [5:0]    idx_q;
  logic [7:0]    cnt;
  logic [TW-1:0] tcnt;
  logic [TW-1:0] tcnt_nxt;
  logic [47:0]   tx_sr;
  logic [126:0]  rx_sr;
  logic [127:0]  rx_full;
  logic [6:0]    crc_tx;
  logic [6:0]    crc_rx;
  logic [7:0]    rx_len;
  logic [7:0]    rx_pos;
  logic [7:0]    crc_lo;
  logic          accept;
  logic          tx_load;
  logic          rx_sample;
  logic          rx_en;
  logic          rx_last;
  logic          crc_bad;

  assign accept    = (state == IDLE) && bus.start;
  assign tx_load   = ((state == PRE) && (cnt == PRE_LEN - 8'd1)) ||
                     ((state == SEND) && (cnt < CMD_CRC_POS));
  assign tcnt_nxt  = tcnt + 1'b1;

  // Only the last 128 bits are kept; start/transmission/reserved bits of R136 are dropped.
  assign rx_full   = {rx_sr, sdcmdin};
  assign rx_len    = (rtype_q == RESP_R136) ? R136_LEN : R48_LEN;
  assign crc_lo    = (rtype_q == RESP_R136) ? 8'd8 : 8'd0;
  assign rx_pos    = (state == RECV) ? cnt : 8'd0;
  assign rx_sample = (state == RECV) || ((state == WAIT_START) && !sdcmdin);
  assign rx_en     = rx_sample && (rx_pos >= crc_lo) && (rx_pos < rx_len - 8'd8);
  assign rx_last   = (state == RECV) && (cnt == rx_len - 8'd1);

  always_comb begin
    crc_bad = ~rx_full[0];
    if ((rtype_q == RESP_R48) && (crc_rx != rx_full[7:1])) crc_bad = 1'b1;
`ifdef SDHOST_R2_CRC_CHECK_EN
    if ((rtype_q == RESP_R136) && (crc_rx != rx_full[7:1])) crc_bad = 1'b1;
`endif
  end

  sd_crc7 u_crc_tx (
    .sdclk(sdclk), .rst_n(rst_n), .clr(accept), .en(tx_load), .din(tx_sr[47]), .crc(crc_tx)
  );

  sd_crc7 u_crc_rx (
    .sdclk(sdclk), .rst_n(rst_n), .clr(accept), .en(rx_en), .din(sdcmdin), .crc(crc_rx)
  );

  always_ff @(posedge sdclk) begin
    if (!rst_n) begin
      state        <= IDLE;
      rtype_q      <= RESP_NONE;
      idx_q        <= '0;
      cnt          <= '0;
      tcnt         <= '0;
      tx_sr        <= '0;
      rx_sr        <= '0;
      sdcmdoe      <= 1'b0;
      sdcmdout     <= 1'b1;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.crc_err  <= 1'b0;
      bus.idx_err  <= 1'b0;
      bus.timeout  <= 1'b0;
      bus.resp_idx <= '0;
      bus.resp_arg <= '0;
    end else begin
      bus.done <= 1'b0;
      if (rx_sample) rx_sr <= rx_full[126:0];
      case (state)
        IDLE: begin
          sdcmdoe  <= 1'b0;
          sdcmdout <= 1'b1;
          if (bus.start) begin
            idx_q        <= bus.cmd_idx;
            rtype_q      <= resp_type_t'(bus.resp_type);
            tx_sr        <= {2'b01, bus.cmd_idx, bus.cmd_arg, 8'h01};
            bus.crc_err  <= 1'b0;
            bus.idx_err  <= 1'b0;
            bus.timeout  <= 1'b0;
            bus.resp_idx <= '0;
            bus.resp_arg <= '0;
            bus.busy     <= 1'b1;
            cnt          <= '0;
            sdcmdoe      <= 1'b1;
            state        <= PRE;
          end
        end
        PRE: begin
          if (cnt == PRE_LEN - 8'd1) begin
            sdcmdout <= tx_sr[47];
            tx_sr    <= {tx_sr[46:0], 1'b0};
            cnt      <= 8'd1;
            state    <= SEND;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        SEND: begin
          if (cnt == CMD_LEN) begin
            sdcmdoe  <= 1'b0;
            sdcmdout <= 1'b1;
            cnt      <= '0;
            if (rtype_q == RESP_NONE) begin
              bus.done <= 1'b1;
              state    <= GAP;
            end else begin
              state <= TURN;
            end
          end else begin
            cnt <= cnt + 8'd1;
            // The CRC is complete once bit 39 has gone out; splice it in ahead of the end bit.
            if (cnt == CMD_CRC_POS) begin
              sdcmdout <= crc_tx[6];
              tx_sr    <= {crc_tx[5:0], 1'b1, 41'd0};
            end else begin
              sdcmdout <= tx_sr[47];
              tx_sr    <= {tx_sr[46:0], 1'b0};
            end
          end
        end
        TURN: begin
          tcnt  <= '0;
          state <= WAIT_START;
        end
        WAIT_START: begin
          if (!sdcmdin) begin
            cnt   <= 8'd1;
            state <= RECV;
          end else if (tcnt_nxt == TO_LIMIT) begin
            bus.timeout <= 1'b1;
            bus.done    <= 1'b1;
            cnt         <= '0;
            state       <= GAP;
          end else begin
            tcnt <= tcnt_nxt;
          end
        end
        RECV: begin
          if (rx_last) begin
            if (rtype_q == RESP_R136) begin
              bus.resp_idx <= '0;
              bus.resp_arg <= rx_full[127:8];
            end else begin
              bus.resp_idx <= rx_full[45:40];
              bus.resp_arg <= {88'd0, rx_full[39:8]};
            end
            bus.crc_err <= crc_bad;
            bus.idx_err <= (rtype_q == RESP_R48) && (rx_full[45:40] != idx_q);
            bus.done    <= 1'b1;
            cnt         <= '0;
            state       <= GAP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_host_cmd.sv
// Directed, table-driven bench for sd_host_cmd with a simple card responder.
module tb_sd_host_cmd;

  logic sdclk = 1'b0;
  logic rst_n;
  logic sdcmdin;
  logic sdcmdoe;
  logic sdcmdout;
  int   checks = 0;
  int   errors = 0;

  sd_host_cmd_if bus ();

  sd_host_cmd #(.RESP_TIMEOUT(64), .NCC(8)) dut (
    .sdclk(sdclk), .rst_n(rst_n), .bus(bus),
    .sdcmdoe(sdcmdoe), .sdcmdout(sdcmdout), .sdcmdin(sdcmdin)
  );

  always #5 sdclk = ~sdclk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // dly: negedges after the command end bit before the card start bit; 0 = card stays silent
  typedef struct {
    logic [5:0]   idx;
    logic [31:0]  arg;
    logic [1:0]   rtype;
    int           dly;
    int           rlen;
    logic [135:0] resp;
    logic [47:0]  frame;
    logic         e_crc;
    logic         e_idx;
    logic         e_to;
    logic [5:0]   e_ridx;
    logic [119:0] e_rarg;
  } vec_t;

  localparam int NVEC = 9;
  localparam logic [119:0] P2 = 120'h00112233445566778899AABBCCDDEE;
  vec_t vecs[NVEC];

  function automatic logic [6:0] crc7(input logic [119:0] v, input int n);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = n - 1; i >= 0; i--) begin
      fb = c[6] ^ v[i];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  function automatic logic [47:0] frame48(input logic tbit, input logic [5:0] idx,
                                          input logic [31:0] arg, input logic [6:0] flip);
    logic [39:0] h;
    h = {1'b0, tbit, idx, arg};
    return {h, crc7({80'd0, h}, 40) ^ flip, 1'b1};
  endfunction

  task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int n);
    vec_t        v;
    logic [49:0] line;
    logic        oe_all;
    int          lat;
    int          g;
    int          w;
    int          exp_lat;
    v = vecs[n];
    w = 0;
    while (bus.busy && w < 200) begin @(negedge sdclk); w++; end
    chk($sformatf("v%0d_idle", n), 136'(bus.busy), 136'd0);
    bus.start = 1'b1; bus.cmd_idx = v.idx; bus.cmd_arg = v.arg; bus.resp_type = v.rtype;
    @(negedge sdclk);
    bus.start = 1'b0;
    line = '0;
    oe_all = 1'b1;
    for (int i = 0; i < 50; i++) begin
      line   = {line[48:0], sdcmdout};
      oe_all = oe_all & sdcmdoe;
      @(negedge sdclk);
    end
    chk($sformatf("v%0d_tx_line", n), 136'(line), 136'({2'b11, v.frame}));
    chk($sformatf("v%0d_tx_oe", n), 136'(oe_all), 136'd1);
    chk($sformatf("v%0d_oe_release", n), 136'(sdcmdoe), 136'd0);
    if (v.rtype != 2'd0 && v.dly != 0) begin
      repeat (v.dly - 1) @(negedge sdclk);
      for (int i = v.rlen - 1; i >= 0; i--) begin
        sdcmdin = v.resp[i];
        @(negedge sdclk);
      end
      sdcmdin = 1'b1;
    end
    lat = 1;
    while (!bus.done && lat < 200) begin @(negedge sdclk); lat++; end
    exp_lat = (v.rtype != 2'd0 && v.dly == 0) ? 66 : 1;
    chk($sformatf("v%0d_done_lat", n), 136'(lat), 136'(exp_lat));
    chk($sformatf("v%0d_crc_err", n), 136'(bus.crc_err), 136'(v.e_crc));
    chk($sformatf("v%0d_idx_err", n), 136'(bus.idx_err), 136'(v.e_idx));
    chk($sformatf("v%0d_timeout", n), 136'(bus.timeout), 136'(v.e_to));
    chk($sformatf("v%0d_resp_idx", n), 136'(bus.resp_idx), 136'(v.e_ridx));
    chk($sformatf("v%0d_resp_arg", n), 136'(bus.resp_arg), 136'(v.e_rarg));
    @(negedge sdclk);
    chk($sformatf("v%0d_done_pulse", n), 136'(bus.done), 136'd0);
    g = 1;
    while (bus.busy && g < 50) begin @(negedge sdclk); g++; end
    chk($sformatf("v%0d_gap_len", n), 136'(g), 136'd8);
    chk($sformatf("v%0d_hold_arg", n), 136'(bus.resp_arg), 136'(v.e_rarg));
  endtask

  initial begin
    int   w;
    int   busy_hi;
    logic oe_seen;
    rst_n = 1'b0; sdcmdin = 1'b1;
    bus.start = 1'b0; bus.cmd_idx = '0; bus.cmd_arg = '0; bus.resp_type = '0;

    vecs[0] = '{6'd0, 32'd0, 2'd0, 0, 48, 136'd0, 48'h400000000095,
                1'b0, 1'b0, 1'b0, 6'd0, 120'd0};
    vecs[1] = '{6'd8, 32'h1AA, 2'd1, 4, 48, 136'(frame48(1'b0, 6'd8, 32'h1AA, 7'h00)),
                48'h48000001AA87, 1'b0, 1'b0, 1'b0, 6'd8, 120'h1AA};
    vecs[2] = '{6'd41, 32'h40FF8000, 2'd3, 5, 48, 136'({2'b00, 6'h3F, 32'hC0FF8000, 7'h7F, 1'b1}),
                frame48(1'b1, 6'd41, 32'h40FF8000, 7'h00), 1'b0, 1'b0, 1'b0, 6'h3F, 120'hC0FF8000};
    vecs[3] = '{6'd17, 32'h200, 2'd1, 3, 48, 136'(frame48(1'b0, 6'd17, 32'h900, 7'h04)),
                frame48(1'b1, 6'd17, 32'h200, 7'h00), 1'b1, 1'b0, 1'b0, 6'd17, 120'h900};
    vecs[4] = '{6'd17, 32'h200, 2'd1, 3, 48, 136'(frame48(1'b0, 6'd16, 32'h900, 7'h00)),
                frame48(1'b1, 6'd17, 32'h200, 7'h00), 1'b0, 1'b1, 1'b0, 6'd16, 120'h900};
    vecs[5] = '{6'd55, 32'h0, 2'd1, 0, 48, 136'd0,
                frame48(1'b1, 6'd55, 32'h0, 7'h00), 1'b0, 1'b0, 1'b1, 6'd0, 120'd0};
    vecs[6] = '{6'd2, 32'h0, 2'd2, 3, 136, {2'b00, 6'h3F, P2, crc7(P2, 120), 1'b1},
                frame48(1'b1, 6'd2, 32'h0, 7'h00), 1'b0, 1'b0, 1'b0, 6'd0, P2};
    vecs[7] = '{6'd41, 32'h40FF8000, 2'd3, 2, 48, 136'({2'b00, 6'h3F, 32'hC0FF8000, 7'h7F, 1'b0}),
                frame48(1'b1, 6'd41, 32'h40FF8000, 7'h00), 1'b1, 1'b0, 1'b0, 6'h3F, 120'hC0FF8000};
    vecs[8] = '{6'd13, 32'h10000, 2'd1, 64, 48, 136'(frame48(1'b0, 6'd13, 32'h900, 7'h00)),
                frame48(1'b1, 6'd13, 32'h10000, 7'h00), 1'b0, 1'b0, 1'b0, 6'd13, 120'h900};

    repeat (3) @(negedge sdclk);
    chk("reset_ctl", 136'({sdcmdoe, sdcmdout, bus.busy, bus.done, bus.crc_err, bus.idx_err, bus.timeout}),
        136'(7'b0100000));
    chk("reset_resp", 136'({bus.resp_idx, bus.resp_arg}), 136'd0);
    rst_n = 1'b1;
    @(negedge sdclk);

    for (int n = 0; n < NVEC; n++) run_vec(n);

    // start raised in the first GAP cycle must be dropped
    bus.start = 1'b1; bus.cmd_idx = 6'd0; bus.cmd_arg = '0; bus.resp_type = 2'd0;
    @(negedge sdclk);
    bus.start = 1'b0;
    w = 0;
    while (!bus.done && w < 100) begin @(negedge sdclk); w++; end
    chk("gs_done", 136'(bus.done), 136'd1);
    bus.start = 1'b1; bus.cmd_idx = 6'd8; bus.resp_type = 2'd1;
    @(negedge sdclk);
    bus.start = 1'b0;
    oe_seen = 1'b0;
    busy_hi = 0;
    for (int i = 0; i < 20; i++) begin
      oe_seen = oe_seen | sdcmdoe;
      if (bus.busy) busy_hi++;
      @(negedge sdclk);
    end
    chk("gs_no_pre", 136'(oe_seen), 136'd0);
    chk("gs_busy_cycles", 136'(busy_hi), 136'd7);

    // reset in the middle of SEND
    bus.start = 1'b1; bus.cmd_idx = 6'd8; bus.cmd_arg = 32'h1AA; bus.resp_type = 2'd1;
    @(negedge sdclk);
    bus.start = 1'b0;
    repeat (12) @(negedge sdclk);
    chk("ms_driving", 136'({sdcmdoe, bus.busy}), 136'(2'b11));
    rst_n = 1'b0;
    @(negedge sdclk);
    chk("ms_reset", 136'({sdcmdoe, sdcmdout, bus.busy, bus.done}), 136'(4'b0100));
    rst_n = 1'b1;
    repeat (3) @(negedge sdclk);
    chk("ms_stays_idle", 136'({sdcmdoe, bus.busy}), 136'd0);
    run_vec(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
